lf_sub_pipe_26: RTL



---
 rtl/lf_sub_pipe_26_pkg.sv | 18 +
 rtl/lf_sub_pipe_26_if.sv | 24 ++
 rtl/lf_sub_pipe_26_carry_op.sv | 14 +
 rtl/lf_sub_pipe_26.sv | 125 ++++++++++++
 4 files changed

// File: rtl/lf_sub_pipe_26_pkg.sv
// Shared arithmetic definitions for the 26-bit Ladner-Fischer datapath blocks.
package lf_arith_pkg;

    localparam int LF_W           = 26;
    localparam int LF_LEVELS      = 5;
    localparam int LF_SPLIT_LEVEL = 3;

    typedef struct packed {
        logic [LF_W-1:0] g;
        logic [LF_W-1:0] p;
    } gp_vec_t;

    // Index of the group a level-k node at bit i combines with.
    function automatic int lf_partner(input int i, input int k);
        return ((i >> k) << k) + (1 << (k - 1)) - 1;
    endfunction

endpackage

// File: rtl/lf_sub_pipe_26_if.sv
// Valid/ready operand and result bus of the pipelined Ladner-Fischer subtractor.
interface lf_sub_pipe_26_if import lf_arith_pkg::*;;

    logic            in_valid;
    logic            in_ready;
    logic [LF_W-1:0] x;
    logic [LF_W-1:0] y;
    logic            out_valid;
    logic            out_ready;
    logic [LF_W-1:0] d;
    logic            borrow;
    logic            zero;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, d, borrow, zero
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, d, borrow, zero
    );

endinterface

// File: rtl/lf_sub_pipe_26_carry_op.sv
// Prefix-tree combine cell: (G,P) = (Gh | Ph&Gl, Ph&Pl).
module lf_carry_op (
    input  logic gh_i,
    input  logic ph_i,
    input  logic gl_i,
    input  logic pl_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = gh_i | (ph_i & gl_i);
    assign p_o = ph_i & pl_i;

endmodule

// File: rtl/lf_sub_pipe_26.sv
// Two-stage 26-bit subtractor D = X - Y on a Ladner-Fischer prefix network,
// computed as X + ~Y + 1, with elastic valid/ready handshake on both sides.
module lf_sub_pipe_26 import lf_arith_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    lf_sub_pipe_26_if.slave    bus
);

    logic [LF_W-1:0]                  g0_s;
    logic [LF_W-1:0]                  p0_s;
    logic [LF_LEVELS-1:0][LF_W-1:0]   src_g_s;
    logic [LF_LEVELS-1:0][LF_W-1:0]   src_p_s;
    logic [LF_LEVELS:1][LF_W-1:0]     out_g_s;
    logic [LF_LEVELS:1][LF_W-1:0]     out_p_s;
    logic [LF_W:0]                    c_s;
    logic [LF_W-1:0]                  diff_s;
    logic                             s1_adv_s;
    logic                             s2_adv_s;

    gp_vec_t                          gp3_d, gp3_q;
    logic [LF_W-1:0]                  p0_d, p0_q;
    logic                             s1_v_d, s1_v_q;
    logic                             s2_v_d, s2_v_q;
    logic [LF_W-1:0]                  d_d, d_q;
    logic                             borrow_d, borrow_q;
    logic                             zero_d, zero_q;

    assign g0_s = bus.x & ~bus.y;
    assign p0_s = bus.x ^ ~bus.y;

    // Level inputs: raw bits at level 0, the stage-1 register after the split.
    for (genvar j = 0; j < LF_LEVELS; j++) begin : g_src
        if (j == 0) begin : g_in
            assign src_g_s[j] = g0_s;
            assign src_p_s[j] = p0_s;
        end else if (j == LF_SPLIT_LEVEL) begin : g_reg
            assign src_g_s[j] = gp3_q.g;
            assign src_p_s[j] = gp3_q.p;
        end else begin : g_chain
            assign src_g_s[j] = out_g_s[j];
            assign src_p_s[j] = out_p_s[j];
        end
    end

    for (genvar k = 1; k <= LF_LEVELS; k++) begin : g_lvl
        for (genvar i = 0; i < LF_W; i++) begin : g_bit
            if (((i >> (k - 1)) & 1) == 1) begin : g_node
                localparam int J = lf_partner(i, k);
                lf_carry_op u_op (
                    .gh_i (src_g_s[k-1][i]),
                    .ph_i (src_p_s[k-1][i]),
                    .gl_i (src_g_s[k-1][J]),
                    .pl_i (src_p_s[k-1][J]),
                    .g_o  (out_g_s[k][i]),
                    .p_o  (out_p_s[k][i])
                );
            end else begin : g_pass
                assign out_g_s[k][i] = src_g_s[k-1][i];
                assign out_p_s[k][i] = src_p_s[k-1][i];
            end
        end
    end

    // Carry-in is 1, so each group propagate also produces a carry.
    assign c_s    = {out_g_s[LF_LEVELS] | out_p_s[LF_LEVELS], 1'b1};
    assign diff_s = p0_q ^ c_s[LF_W-1:0];

    // Stage advance and next-state for valid bits and data registers.
    always_comb begin
        s2_adv_s = ~s2_v_q | bus.out_ready;
        s1_adv_s = ~s1_v_q | s2_adv_s;
        s1_v_d   = s1_adv_s ? bus.in_valid : s1_v_q;
        s2_v_d   = s2_adv_s ? s1_v_q : s2_v_q;
        gp3_d    = gp3_q;
        p0_d     = p0_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        if (s1_adv_s && bus.in_valid) begin
            gp3_d.g = out_g_s[LF_SPLIT_LEVEL];
            gp3_d.p = out_p_s[LF_SPLIT_LEVEL];
            p0_d    = p0_s;
        end else begin
            gp3_d   = gp3_q;
            p0_d    = p0_q;
        end
        if (s2_adv_s && s1_v_q) begin
            d_d      = diff_s;
            borrow_d = ~c_s[LF_W];
            zero_d   = ~|diff_s;
        end else begin
            d_d      = d_q;
            borrow_d = borrow_q;
            zero_d   = zero_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            gp3_q    <= '0;
            p0_q     <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            gp3_q    <= gp3_d;
            p0_q     <= p0_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = s2_v_q;
    assign bus.d         = d_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;

endmodule
